// File: rtl/burst_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : burst_rr_sched_pkg
// Brief  : Shared state type and owner-width helper for the burst RR scheduler.
// Rev    : 1.0
// ============================================================================
package burst_rr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  // At least one bit even for a degenerate single-client instance.
  function automatic int owner_width(input int clients);
    return (clients > 1) ? $clog2(clients) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_next_picker
// Brief  : Combinational rotating-priority search, first eligible after pointer.
// Rev    : 1.0
// ============================================================================
module rr_next_picker
  import burst_rr_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = owner_width(N)
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_pointer,
  output logic             o_found,
  output logic [IDX_W-1:0] o_index
);

  int               w_cand;
  logic [IDX_W-1:0] w_idx;

  // The pointer itself is visited last, so the previous owner yields to others.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = 0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = int'(i_pointer) + i;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      w_idx = IDX_W'(w_cand);
      if (!o_found && i_eligible[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_rr_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module : burst_rr_drain_scheduler
// Brief  : Weighted-burst round-robin drain of CLIENTS source FIFOs into one sink.
// Rev    : 1.0
// ============================================================================
module burst_rr_drain_scheduler
  import burst_rr_sched_pkg::*;
#(
  parameter int CLIENTS    = 4,
  parameter int WEIGHT_W   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [CLIENTS*WEIGHT_W-1:0]      i_cfg_weight,
  input  logic                             i_block,
  input  logic [CLIENTS-1:0]               i_src_empty,
  input  logic [CLIENTS*DATA_WIDTH-1:0]    i_src_data,
  output logic [CLIENTS-1:0]               o_src_read,
  input  logic                             i_dst_full,
  output logic                             o_dst_write,
  output logic [DATA_WIDTH-1:0]            o_dst_data,
  output logic [owner_width(CLIENTS)-1:0]  o_owner,
  output logic                             o_busy,
  output logic                             o_burst_done
);

  localparam int c_OWNER_W = owner_width(CLIENTS);

  logic [WEIGHT_W-1:0]   w_weight [CLIENTS];
  logic [DATA_WIDTH-1:0] w_data   [CLIENTS];
  logic [CLIENTS-1:0]    w_eligible;
  logic                  w_found;
  logic [c_OWNER_W-1:0]  w_pick;

  sched_state_t          r_state, w_state_nxt;
  logic [c_OWNER_W-1:0]  r_owner, w_owner_nxt;
  logic [c_OWNER_W-1:0]  r_ptr,   w_ptr_nxt;
  logic [WEIGHT_W-1:0]   r_count, w_count_nxt;
  logic                  r_done,  w_done_nxt;
  logic                  w_xfer;

  for (genvar k = 0; k < CLIENTS; k++) begin : g_client
    assign w_weight[k]   = i_cfg_weight[k*WEIGHT_W +: WEIGHT_W];
    assign w_data[k]     = i_src_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_eligible[k] = ~i_src_empty[k] & (|w_weight[k]);
  end

  rr_next_picker #(
    .N     (CLIENTS),
    .IDX_W (c_OWNER_W)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_pointer  (r_ptr),
    .o_found    (w_found),
    .o_index    (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_block && w_found) begin
          w_owner_nxt = w_pick;
          w_count_nxt = w_weight[w_pick];
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        // Empty is checked before full so a drained owner never holds the sink.
        if (i_block || i_src_empty[r_owner]) begin
          w_state_nxt = IDLE;
        end else if (!i_dst_full) begin
          w_xfer      = 1'b1;
          w_count_nxt = r_count - 1'b1;
          if (r_count == WEIGHT_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
        if (w_state_nxt == IDLE) begin
          w_ptr_nxt  = r_owner;
          w_done_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= c_OWNER_W'(CLIENTS - 1);
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    o_src_read = '0;
    if (w_xfer) begin
      o_src_read[r_owner] = 1'b1;
    end
  end

  assign o_dst_write  = w_xfer;
  assign o_dst_data   = w_data[r_owner];
  assign o_owner      = r_owner;
  assign o_busy       = (r_state == BURST);
  assign o_burst_done = r_done;

  a_read_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_src_read));
  a_write_eq_read : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_dst_write == (|o_src_read));
  a_no_write_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_dst_write && i_dst_full));
  a_no_read_empty : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_src_read & i_src_empty) == '0);

endmodule
`default_nettype wire
